seq_complement_unit: RTL

- Multi-cycle, parametrised successor to the ALU's combinational 32-bit complement block.
- Computes one's complement, two's complement, absolute value or pass-through of a WIDTH-bit operand, CHUNK bits per cycle, using a registered carry. This keeps the carry chain short for timing.
- Sits beside the ALU and uses a start/busy/done handshake with the control unit.

---
 rtl/seq_complement_unit_if.sv | 33 +++
 rtl/seq_complement_unit.sv | 135 +++++++++++++
 2 files changed

// File: rtl/seq_complement_unit_if.sv
// Handshake/bus bundle between the control unit (master) and seq_complement_unit (slave).
// ZF/NF exist only when SEQ_COMPLEMENT_FLAGS_EN is defined.
interface seq_complement_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       mode;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             OVF;
`ifdef SEQ_COMPLEMENT_FLAGS_EN
    logic             ZF;
    logic             NF;
`endif

    modport master (
        output start, mode, A,
`ifdef SEQ_COMPLEMENT_FLAGS_EN
        input  ZF, NF,
`endif
        input  B, busy, done, OVF
    );

    modport slave (
        input  start, mode, A,
`ifdef SEQ_COMPLEMENT_FLAGS_EN
        output ZF, NF,
`endif
        output B, busy, done, OVF
    );
endinterface

// File: rtl/seq_complement_unit.sv
// Multi-cycle one's/two's complement, absolute value and pass-through, CHUNK bits per cycle
// with a registered carry. Optional ZF/NF result flags under SEQ_COMPLEMENT_FLAGS_EN.
module seq_complement_unit #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_complement_unit_if.slave bus
);
    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q, b_d;
    logic             inv_q;
    logic             carry_q;
    logic             ovf_q;
    logic             ovf_pend_q;
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] lsb;
    logic [CHUNK-1:0] x_chunk;
    logic [CHUNK:0]   sum;
    logic             accept;
    logic             last;
    logic             neg_in;
    logic             inv_in;
    logic             min_in;
`ifdef SEQ_COMPLEMENT_FLAGS_EN
    logic             zf_q;
    logic             nf_q;
`endif

    function automatic logic [CHUNK:0] chunk_add(input logic [CHUNK-1:0] x, input logic cin);
        return {1'b0, x} + {{CHUNK{1'b0}}, cin};
    endfunction

    assign accept = (state_q == IDLE) && bus.start;
    assign last   = (cnt_q == CNT_W'(N - 1));

    // Negation happens for two's complement always, and for abs only on a negative operand.
    assign neg_in = (bus.mode == 2'b01) || ((bus.mode == 2'b10) && bus.A[WIDTH-1]);
    assign inv_in = (bus.mode == 2'b00) || neg_in;
    assign min_in = (bus.A == {1'b1, {(WIDTH-1){1'b0}}});

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Chunk datapath: select current slice, optionally invert, add the carry.
    always_comb begin
        lsb     = IDX_W'(cnt_q) * IDX_W'(CHUNK);
        x_chunk = a_q[lsb +: CHUNK];
        if (inv_q) begin
            x_chunk = ~x_chunk;
        end
        sum            = chunk_add(x_chunk, carry_q);
        b_d            = b_q;
        b_d[lsb +: CHUNK] = sum[CHUNK-1:0];
    end

    // Operand and per-op decode are pure data: loaded on accept, never reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q        <= bus.A;
            inv_q      <= inv_in;
            ovf_pend_q <= neg_in && min_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            b_q     <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
`ifdef SEQ_COMPLEMENT_FLAGS_EN
            zf_q    <= 1'b0;
            nf_q    <= 1'b0;
`endif
        end else if (accept) begin
            b_q     <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            carry_q <= neg_in;
`ifdef SEQ_COMPLEMENT_FLAGS_EN
            zf_q    <= 1'b0;
            nf_q    <= 1'b0;
`endif
        end else if (state_q == RUN) begin
            b_q     <= b_d;
            carry_q <= sum[CHUNK];
            cnt_q   <= cnt_q + CNT_W'(1);
            if (last) begin
                ovf_q <= ovf_pend_q;
`ifdef SEQ_COMPLEMENT_FLAGS_EN
                zf_q  <= (b_d == '0);
                nf_q  <= b_d[WIDTH-1];
`endif
            end
        end
    end

    assign bus.B    = b_q;
    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.OVF  = ovf_q;
`ifdef SEQ_COMPLEMENT_FLAGS_EN
    assign bus.ZF   = zf_q;
    assign bus.NF   = nf_q;
`endif

endmodule
